// File: rtl/unidade_multdiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: default width,
// operation codes, FSM state encoding and the iteration counter width.
package pacote_multdiv;

    localparam int LARGURA_PADRAO = 32;

    // Operation codes as presented on Operacao together with Inicio
    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    // Control FSM states
    typedef enum logic [1:0] {
        OCIOSO  = 2'b00,
        PREPARA = 2'b01,
        CALCULA = 2'b10,
        AJUSTA  = 2'b11
    } estado_e;

    // Counter width able to index every iteration; never narrower than one bit
    function automatic int largura_contador(input int iteracoes);
        return (iteracoes > 1) ? $clog2(iteracoes) : 1;
    endfunction

    localparam int LARGURA_CONT_PADRAO = largura_contador(LARGURA_PADRAO);

endpackage

// File: rtl/unidade_multdiv_passo.sv
// One combinational iteration of the multiply/divide datapath.
// Multiply: shift-add on a {partial product, remaining multiplier} accumulator.
// Divide: restoring shift-subtract on a {remainder, dividend/quotient} accumulator;
// the quotient bit is returned separately and merged by the wrapper.
import pacote_multdiv::*;

module passo_multdiv #(
    parameter int LARGURA = LARGURA_PADRAO
) (
    input  logic [2*LARGURA-1:0] acumulador,
    input  logic [LARGURA-1:0]   operando,
    input  logic                 divide,
    output logic [2*LARGURA-1:0] acumulador_prox,
    output logic                 bit_quociente
);

    logic [LARGURA-1:0] parte_alta;
    logic [LARGURA-1:0] parte_baixa;
    logic [LARGURA:0]   resto_desl;
    logic [LARGURA:0]   soma;
    logic               cabe;

    // Compute both candidate steps and select by mode
    always_comb begin
        parte_alta      = acumulador[2*LARGURA-1:LARGURA];
        parte_baixa     = acumulador[LARGURA-1:0];
        resto_desl      = {parte_alta, parte_baixa[LARGURA-1]};
        cabe            = (resto_desl >= {1'b0, operando});
        soma            = {1'b0, parte_alta} + (parte_baixa[0] ? {1'b0, operando} : '0);
        acumulador_prox = '0;
        bit_quociente   = 1'b0;
        if (divide) begin
            if (cabe) begin
                acumulador_prox = {resto_desl[LARGURA-1:0] - operando,
                                   parte_baixa[LARGURA-2:0], 1'b0};
                bit_quociente   = 1'b1;
            end else begin
                acumulador_prox = {resto_desl[LARGURA-1:0],
                                   parte_baixa[LARGURA-2:0], 1'b0};
            end
        end else begin
            acumulador_prox = {soma, parte_baixa[LARGURA-1:1]};
        end
    end

endmodule

// File: rtl/unidade_multdiv.sv
// Iterative multiply/divide unit with private HI/LO registers (mult, multu,
// div, divu, mthi, mtlo). Signed operations run on magnitudes and the signs
// are applied in the final cycle.
// Optional feature macro: MULTDIV_DIVZERO_EN -- early exit on a zero divisor
// with a sticky DivZero flag and HI/LO left untouched.
import pacote_multdiv::*;

module unidade_multdiv #(
    parameter int LARGURA   = LARGURA_PADRAO,
    parameter int ITERACOES = LARGURA
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Inicio,
    input  logic [1:0]         Operacao,
    input  logic [LARGURA-1:0] OperandoA,
    input  logic [LARGURA-1:0] OperandoB,
    input  logic               EscreveHi,
    input  logic               EscreveLo,
    input  logic [LARGURA-1:0] DadoEscrita,
    output logic [LARGURA-1:0] Hi,
    output logic [LARGURA-1:0] Lo,
    output logic               Ocupado,
    output logic               Pronto
`ifdef MULTDIV_DIVZERO_EN
    ,
    output logic               DivZero
`endif
);

    localparam int LARGURA_CONT = largura_contador(ITERACOES);

    estado_e                 estado_q, estado_d;
    op_e                     op_q, op_d;
    logic [LARGURA-1:0]      opa_q, opa_d;
    logic [LARGURA-1:0]      opb_q, opb_d;
    logic [LARGURA-1:0]      operando_q, operando_d;
    logic [2*LARGURA-1:0]    acc_q, acc_d;
    logic [LARGURA_CONT-1:0] cont_q, cont_d;
    logic                    neg_res_q, neg_res_d;
    logic                    neg_rem_q, neg_rem_d;
    logic [LARGURA-1:0]      hi_q, hi_d;
    logic [LARGURA-1:0]      lo_q, lo_d;
    logic                    pronto_q, pronto_d;
`ifdef MULTDIV_DIVZERO_EN
    logic                    divzero_q, divzero_d;
    logic                    zero_pend_q, zero_pend_d;
    logic                    divisor_zero;
`endif

    logic                    e_divisao;
    logic                    e_com_sinal;
    logic                    sinal_a;
    logic                    sinal_b;
    logic [LARGURA-1:0]      mag_a;
    logic [LARGURA-1:0]      mag_b;
    logic [2*LARGURA-1:0]    produto_final;
    logic [LARGURA-1:0]      quoc_final;
    logic [LARGURA-1:0]      resto_final;
    logic [2*LARGURA-1:0]    acc_passo;
    logic                    bit_quociente;

    assign e_divisao     = (op_q == OP_DIV) || (op_q == OP_DIVU);
    assign e_com_sinal   = (op_q == OP_MULT) || (op_q == OP_DIV);
    assign sinal_a       = e_com_sinal & opa_q[LARGURA-1];
    assign sinal_b       = e_com_sinal & opb_q[LARGURA-1];
    assign mag_a         = sinal_a ? -opa_q : opa_q;
    assign mag_b         = sinal_b ? -opb_q : opb_q;
    assign produto_final = neg_res_q ? -acc_q : acc_q;
    assign quoc_final    = neg_res_q ? -acc_q[LARGURA-1:0] : acc_q[LARGURA-1:0];
    assign resto_final   = neg_rem_q ? -acc_q[2*LARGURA-1:LARGURA] : acc_q[2*LARGURA-1:LARGURA];
`ifdef MULTDIV_DIVZERO_EN
    assign divisor_zero  = e_divisao && (opb_q == '0);
`endif

    passo_multdiv #(
        .LARGURA(LARGURA)
    ) u_passo (
        .acumulador     (acc_q),
        .operando       (operando_q),
        .divide         (e_divisao),
        .acumulador_prox(acc_passo),
        .bit_quociente  (bit_quociente)
    );

    // Next-state and datapath control; every register holds unless its state acts on it
    always_comb begin
        estado_d   = estado_q;
        op_d       = op_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        operando_d = operando_q;
        acc_d      = acc_q;
        cont_d     = cont_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        pronto_d   = 1'b0;
`ifdef MULTDIV_DIVZERO_EN
        divzero_d   = divzero_q;
        zero_pend_d = zero_pend_q;
`endif
        case (estado_q)
            OCIOSO: begin
                if (Inicio) begin
                    estado_d = PREPARA;
                    op_d     = op_e'(Operacao);
                    opa_d    = OperandoA;
                    opb_d    = OperandoB;
`ifdef MULTDIV_DIVZERO_EN
                    divzero_d   = 1'b0;
                    zero_pend_d = 1'b0;
`endif
                end else begin
                    if (EscreveHi) begin
                        hi_d = DadoEscrita;
                    end
                    if (EscreveLo) begin
                        lo_d = DadoEscrita;
                    end
                end
            end
            PREPARA: begin
                neg_res_d = sinal_a ^ sinal_b;
                neg_rem_d = sinal_a;
                cont_d    = '0;
                if (e_divisao) begin
                    operando_d = mag_b;
                    acc_d      = {{LARGURA{1'b0}}, mag_a};
                end else begin
                    operando_d = mag_a;
                    acc_d      = {{LARGURA{1'b0}}, mag_b};
                end
                estado_d = CALCULA;
`ifdef MULTDIV_DIVZERO_EN
                if (divisor_zero) begin
                    if (!zero_pend_q) begin
                        zero_pend_d = 1'b1;
                        estado_d    = PREPARA;
                    end else begin
                        zero_pend_d = 1'b0;
                        divzero_d   = 1'b1;
                        pronto_d    = 1'b1;
                        estado_d    = OCIOSO;
                    end
                end
`endif
            end
            CALCULA: begin
                acc_d  = acc_passo | {{(2*LARGURA-1){1'b0}}, bit_quociente};
                cont_d = cont_q + LARGURA_CONT'(1);
                if (cont_q == LARGURA_CONT'(ITERACOES - 1)) begin
                    estado_d = AJUSTA;
                end
            end
            AJUSTA: begin
                if (e_divisao) begin
                    hi_d = resto_final;
                    lo_d = quoc_final;
                end else begin
                    hi_d = produto_final[2*LARGURA-1:LARGURA];
                    lo_d = produto_final[LARGURA-1:0];
                end
                pronto_d = 1'b1;
                estado_d = OCIOSO;
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase
    end

    // State register with synchronous reset that also clears HI/LO and aborts any operation
    always_ff @(posedge Clock) begin
        if (Reset) begin
            estado_q   <= OCIOSO;
            op_q       <= OP_MULT;
            opa_q      <= '0;
            opb_q      <= '0;
            operando_q <= '0;
            acc_q      <= '0;
            cont_q     <= '0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            pronto_q   <= 1'b0;
`ifdef MULTDIV_DIVZERO_EN
            divzero_q   <= 1'b0;
            zero_pend_q <= 1'b0;
`endif
        end else begin
            estado_q   <= estado_d;
            op_q       <= op_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            operando_q <= operando_d;
            acc_q      <= acc_d;
            cont_q     <= cont_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            pronto_q   <= pronto_d;
`ifdef MULTDIV_DIVZERO_EN
            divzero_q   <= divzero_d;
            zero_pend_q <= zero_pend_d;
`endif
        end
    end

    assign Hi      = hi_q;
    assign Lo      = lo_q;
    assign Ocupado = (estado_q != OCIOSO);
    assign Pronto  = pronto_q;
`ifdef MULTDIV_DIVZERO_EN
    assign DivZero = divzero_q;
`endif

endmodule

// File: tb/tb_unidade_multdiv.sv
// Testbench for unidade_multdiv: directed operations with a result scoreboard,
// cycle-exact busy/ready checks, register writes, divide-by-zero and reset abort.
// Honours MULTDIV_DIVZERO_EN when the design is built with it.
module tb_unidade_multdiv;

    localparam logic [1:0] MULT  = 2'b00;
    localparam logic [1:0] MULTU = 2'b01;
    localparam logic [1:0] DIV   = 2'b10;
    localparam logic [1:0] DIVU  = 2'b11;
    localparam int LATENCIA = 34;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } resultado_t;

    logic        Clock;
    logic        Reset;
    logic        Inicio;
    logic [1:0]  Operacao;
    logic [31:0] OperandoA;
    logic [31:0] OperandoB;
    logic        EscreveHi;
    logic        EscreveLo;
    logic [31:0] DadoEscrita;
    logic [31:0] Hi;
    logic [31:0] Lo;
    logic        Ocupado;
    logic        Pronto;
`ifdef MULTDIV_DIVZERO_EN
    logic        DivZero;
`endif

    int          testsRun = 0;
    int          testsFailed = 0;
    resultado_t  sbQueue[$];
    resultado_t  monitorEsperado;
    logic [31:0] modelHi;
    logic [31:0] modelLo;

    unidade_multdiv dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Inicio     (Inicio),
        .Operacao   (Operacao),
        .OperandoA  (OperandoA),
        .OperandoB  (OperandoB),
        .EscreveHi  (EscreveHi),
        .EscreveLo  (EscreveLo),
        .DadoEscrita(DadoEscrita),
        .Hi         (Hi),
        .Lo         (Lo),
        .Ocupado    (Ocupado),
        .Pronto     (Pronto)
`ifdef MULTDIV_DIVZERO_EN
        ,
        .DivZero    (DivZero)
`endif
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // One counted comparison
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Reference behaviour from plain arithmetic
    function automatic resultado_t refModel(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        resultado_t              r;
        logic signed [63:0]      ps;
        logic        [63:0]      pu;
        logic signed [31:0]      sa;
        logic signed [31:0]      sb;
        sa = a;
        sb = b;
        r  = '0;
        case (op)
            MULT: begin
                ps = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                r  = {ps[63:32], ps[31:0]};
            end
            MULTU: begin
                pu = {32'd0, a} * {32'd0, b};
                r  = {pu[63:32], pu[31:0]};
            end
            DIVU: begin
                if (b == 32'd0) r = {a, 32'hFFFFFFFF};
                else            r = {a % b, a / b};
            end
            default: begin
                if (b == 32'd0)                                  r = {a, (a[31] ? 32'h00000001 : 32'hFFFFFFFF)};
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = {32'd0, 32'h80000000};
                else                                             r = {32'(sa % sb), 32'(sa / sb)};
            end
        endcase
        return r;
    endfunction

    // Starts one operation and checks busy/ready timing cycle by cycle.
    // modo: 0 plain, 1 Inicio+EscreveHi injected while busy, 2 EscreveHi together with Inicio
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input resultado_t esperado, input int latencia, input int modo);
        Inicio    = 1'b1;
        Operacao  = op;
        OperandoA = a;
        OperandoB = b;
        if (modo == 2) begin
            EscreveHi   = 1'b1;
            DadoEscrita = 32'hCAFEF00D;
        end
        sbQueue.push_back(esperado);
        @(posedge Clock); #1;
        Inicio    = 1'b0;
        EscreveHi = 1'b0;
        OperandoA = $urandom;
        OperandoB = $urandom;
        for (int k = 0; k < latencia; k++) begin
            checkOutput("ocupado_pronto", {62'd0, Ocupado, Pronto}, 64'd2);
            if (modo == 1 && k == 5) begin
                Inicio      = 1'b1;
                Operacao    = MULTU;
                EscreveHi   = 1'b1;
                DadoEscrita = 32'hDEADBEEF;
            end
            if (k == 6) begin
                Inicio    = 1'b0;
                EscreveHi = 1'b0;
            end
            if (k == 10) begin
                checkOutput("hi_mantido", {32'd0, Hi}, {32'd0, modelHi});
                checkOutput("lo_mantido", {32'd0, Lo}, {32'd0, modelLo});
            end
            @(posedge Clock); #1;
        end
        checkOutput("fim_ocupado_pronto", {62'd0, Ocupado, Pronto}, 64'd1);
        modelHi = esperado.hi;
        modelLo = esperado.lo;
        @(posedge Clock); #1;
        checkOutput("pronto_um_ciclo", {62'd0, Ocupado, Pronto}, 64'd0);
    endtask

    // Scoreboard: every Pronto pulse must match the oldest outstanding result
    always @(negedge Clock) begin
        if (!Reset && Pronto) begin
            if (sbQueue.size() == 0) begin
                checkOutput("pronto_inesperado", {63'd0, Pronto}, 64'd0);
            end else begin
                monitorEsperado = sbQueue.pop_front();
                checkOutput("sb_hi", {32'd0, Hi}, {32'd0, monitorEsperado.hi});
                checkOutput("sb_lo", {32'd0, Lo}, {32'd0, monitorEsperado.lo});
            end
        end
    end

    initial begin
        logic [1:0]  opAleat;
        logic [31:0] aAleat;
        logic [31:0] bAleat;

        Reset       = 1'b1;
        Inicio      = 1'b0;
        Operacao    = MULT;
        OperandoA   = '0;
        OperandoB   = '0;
        EscreveHi   = 1'b0;
        EscreveLo   = 1'b0;
        DadoEscrita = '0;
        modelHi     = '0;
        modelLo     = '0;
        repeat (2) @(posedge Clock);
        #1;
        checkOutput("reset_hi", {32'd0, Hi}, 64'd0);
        checkOutput("reset_lo", {32'd0, Lo}, 64'd0);
        checkOutput("reset_ocupado_pronto", {62'd0, Ocupado, Pronto}, 64'd0);
`ifdef MULTDIV_DIVZERO_EN
        checkOutput("reset_divzero", {63'd0, DivZero}, 64'd0);
`endif
        Reset = 1'b0;
        @(posedge Clock); #1;

        applyStimulus(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, '{32'hFFFFFFFE, 32'h00000001}, LATENCIA, 0);
        applyStimulus(MULT,  32'hFFFFFFFD, 32'd7,        '{32'hFFFFFFFF, 32'hFFFFFFEB}, LATENCIA, 0);
        applyStimulus(DIV,   32'hFFFFFFF9, 32'd2,        '{32'hFFFFFFFF, 32'hFFFFFFFD}, LATENCIA, 0);
        applyStimulus(DIVU,  32'd100,      32'd7,        '{32'd2, 32'd14},              LATENCIA, 0);
        applyStimulus(DIV,   32'h80000000, 32'hFFFFFFFF, '{32'd0, 32'h80000000},        LATENCIA, 0);
        applyStimulus(DIV,   32'd45,       32'hFFFFFFFA, '{32'd3, 32'hFFFFFFF9},        LATENCIA, 0);

        EscreveLo   = 1'b1;
        DadoEscrita = 32'h00001234;
        @(posedge Clock); #1;
        EscreveLo = 1'b0;
        checkOutput("mtlo_lo", {32'd0, Lo}, 64'h1234);
        checkOutput("mtlo_hi", {32'd0, Hi}, {32'd0, modelHi});
        modelLo = 32'h00001234;
        EscreveHi   = 1'b1;
        DadoEscrita = 32'h0000ABCD;
        @(posedge Clock); #1;
        EscreveHi = 1'b0;
        checkOutput("mthi_hi", {32'd0, Hi}, 64'hABCD);
        modelHi = 32'h0000ABCD;

        applyStimulus(DIVU, 32'd1000, 32'd3, '{32'd1, 32'd333}, LATENCIA, 1);
        applyStimulus(MULT, 32'd6,    32'd7, '{32'd0, 32'd42},  LATENCIA, 2);

`ifdef MULTDIV_DIVZERO_EN
        applyStimulus(DIVU, 32'd5, 32'd0, '{modelHi, modelLo}, 2, 0);
        checkOutput("divzero_set", {63'd0, DivZero}, 64'd1);
        applyStimulus(DIV, 32'hFFFFFFF8, 32'd0, '{modelHi, modelLo}, 2, 0);
        checkOutput("divzero_set2", {63'd0, DivZero}, 64'd1);
        applyStimulus(DIVU, 32'd9, 32'd3, '{32'd0, 32'd3}, LATENCIA, 0);
        checkOutput("divzero_clear", {63'd0, DivZero}, 64'd0);
`else
        applyStimulus(DIVU, 32'd5,        32'd0, '{32'd5, 32'hFFFFFFFF},        LATENCIA, 0);
        applyStimulus(DIV,  32'hFFFFFFF8, 32'd0, '{32'hFFFFFFF8, 32'd1},        LATENCIA, 0);
        applyStimulus(DIV,  32'd9,        32'd0, '{32'd9, 32'hFFFFFFFF},        LATENCIA, 0);
`endif

        for (int i = 0; i < 4; i++) begin
            opAleat = 2'($urandom_range(0, 3));
            aAleat  = $urandom;
            bAleat  = $urandom;
            if (i == 1) bAleat = bAleat >> 20;
            if (bAleat == 32'd0) bAleat = 32'd1;
            applyStimulus(opAleat, aAleat, bAleat, refModel(opAleat, aAleat, bAleat), LATENCIA, 0);
        end

        Inicio    = 1'b1;
        Operacao  = MULT;
        OperandoA = 32'h12345678;
        OperandoB = 32'h9ABCDEF0;
        sbQueue.push_back(refModel(MULT, 32'h12345678, 32'h9ABCDEF0));
        @(posedge Clock); #1;
        Inicio = 1'b0;
        repeat (10) @(posedge Clock);
        #1;
        Reset = 1'b1;
        sbQueue.delete();
        @(posedge Clock); #1;
        checkOutput("abort_ocupado_pronto", {62'd0, Ocupado, Pronto}, 64'd0);
        checkOutput("abort_hi", {32'd0, Hi}, 64'd0);
        checkOutput("abort_lo", {32'd0, Lo}, 64'd0);
        Reset   = 1'b0;
        modelHi = '0;
        modelLo = '0;
        for (int k = 0; k < 40; k++) begin
            @(posedge Clock); #1;
            checkOutput("abort_sem_pronto", {62'd0, Ocupado, Pronto}, 64'd0);
        end

        checkOutput("sb_vazio", 64'(sbQueue.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
